// File: rtl/imem_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// imem_fetch_sequencer
//   Owns the program counter and drives a zero-latency, word-indexed
//   instruction memory. Presents one instruction at a time to decode over a
//   valid/ready handshake. Handles taken-branch redirects from execute, flushes
//   the wrong-path slot, and stops at end of program, on halt, or on an
//   out-of-range branch target.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset_n      synchronous active-low reset
//   start        pulse: begin fetching at RESET_PC (honoured in IDLE/DONE only)
//   halt         level: abandon the stream and go to DONE
//   imem_addr    address to instruction memory (= current PC, combinational)
//   imem_rdata   instruction word returned by memory in the same cycle
//   inst_out     registered instruction to decode
//   inst_pc      PC of inst_out
//   inst_valid   inst_out/inst_pc hold a live instruction
//   inst_ready   decode accepts the instruction this cycle
//   br_taken     pulse: redirect the PC to br_target
//   br_target    absolute word address of the branch target
//   busy         high while fetching (FETCH or HOLD)
//   done         high in DONE
//   fault        sticky: a redirect targeted an address >= DEPTH
//   fetch_count  number of accepted instructions, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module imem_fetch_sequencer #(
  parameter int BITSIZE  = 32,
  parameter int REGSIZE  = 64,
  parameter int DEPTH    = 64,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               halt,
  output logic [REGSIZE-1:0] imem_addr,
  input  logic [BITSIZE-1:0] imem_rdata,
  output logic [BITSIZE-1:0] inst_out,
  output logic [REGSIZE-1:0] inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               br_taken,
  input  logic [REGSIZE-1:0] br_target,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [REGSIZE-1:0] LAST_PC  = REGSIZE'(DEPTH - 1);
  localparam logic [REGSIZE-1:0] DEPTH_W  = REGSIZE'(DEPTH);
  localparam logic [REGSIZE-1:0] START_PC = REGSIZE'(RESET_PC);

  state_t               state_q;
  logic [REGSIZE-1:0]   pc_q;
  logic [BITSIZE-1:0]   inst_q;
  logic [REGSIZE-1:0]   ipc_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 fault_q;
  // Set once the last memory word has been loaded into the slot; no further
  // fetch happens and the stream ends when that word is accepted.
  logic                 last_q;
  logic [15:0]          cnt_q;
  logic [15:0]          cnt_d;

  logic accept_s;
  logic tgt_oob_s;
  logic pc_at_last_s;

  assign accept_s     = valid_q && inst_ready;
  assign tgt_oob_s    = (br_target >= DEPTH_W);
  assign pc_at_last_s = (pc_q == LAST_PC);
  assign cnt_d        = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);

  // Fetch FSM: PC, instruction slot, status flags and accept counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      inst_q  <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            pc_q    <= START_PC;
            last_q  <= 1'b0;
            fault_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH, S_HOLD: begin
          if (br_taken) begin
            // The slot holds a wrong-path instruction: drop it uncounted.
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (tgt_oob_s) begin
              fault_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pc_q    <= br_target;
              state_q <= S_FETCH;
            end
          end else begin
            if (accept_s) begin
              cnt_q <= cnt_d;
            end
            if (halt) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (valid_q && !inst_ready) begin
              state_q <= S_HOLD;
            end else if (last_q) begin
              // Final word has just been accepted (slot is free here).
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              inst_q  <= imem_rdata;
              ipc_q   <= pc_q;
              valid_q <= 1'b1;
              // PC parks on the last word instead of wrapping.
              if (pc_at_last_s) begin
                last_q <= 1'b1;
              end else begin
                pc_q <= pc_q + REGSIZE'(1);
              end
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          if (start) begin
            pc_q    <= START_PC;
            last_q  <= 1'b0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign inst_out    = inst_q;
  assign inst_pc     = ipc_q;
  assign inst_valid  = valid_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_HOLD);
  assign done        = done_q;
  assign fault       = fault_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_sequencer
//   Directed bench for imem_fetch_sequencer. A behavioural 64-word memory feeds
//   the DUT; expected PCs are queued as stimulus is issued and popped on each
//   valid&&ready handshake, where the presented PC and word are compared.
// -----------------------------------------------------------------------------
module tb_imem_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        halt;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        br_taken;
  logic [63:0] br_target;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] fetch_count;

  logic [31:0] mem [64];
  logic [63:0] sb_q [$];
  int          total = 0;
  int          bad = 0;
  int          exp_cnt = 0;
  int          cyc;

  always #5 clk = ~clk;

  imem_fetch_sequencer #(
    .BITSIZE(32), .REGSIZE(64), .DEPTH(64), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .br_taken(br_taken), .br_target(br_target),
    .busy(busy), .done(done), .fault(fault), .fetch_count(fetch_count)
  );

  always_comb begin
    imem_rdata = 32'd0;
    if (imem_addr < 64'd64) imem_rdata = mem[imem_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sb_q.push_back(64'(i));
  endtask

  // One clock: score the handshake the coming edge will perform, then advance.
  task automatic tick();
    logic [63:0] p;
    if (reset_n && inst_valid && inst_ready && !br_taken) begin
      exp_cnt++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed_pc=%0h expected=none", inst_pc);
      end else begin
        p = sb_q.pop_front();
        chk("sb_pc", inst_pc, p);
        chk("sb_inst", 64'(inst_out), 64'(mem[p[5:0]]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // MOVK xN, #N encodings as memory contents
    for (int i = 0; i < 64; i++) mem[i] = 32'hF280_0000 | 32'(i << 5) | 32'(i % 32);

    // 1: reset held with start asserted
    reset_n = 1'b0; start = 1'b1; halt = 1'b0; inst_ready = 1'b0;
    br_taken = 1'b0; br_target = 64'd0;
    tick(); tick();
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_out", 64'(inst_out), 64'd0);
    chk("rst_pc", inst_pc, 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_cnt", 64'(fetch_count), 64'd0);

    // 2: straight-line fetch
    reset_n = 1'b1; start = 1'b1; inst_ready = 1'b1;
    push_range(0, 63);
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_lat_valid", 64'(inst_valid), 64'd0);
    tick();
    chk("first_valid", 64'(inst_valid), 64'd1);
    chk("first_pc", inst_pc, 64'd0);
    tick(); tick(); tick();
    chk("cnt3", 64'(fetch_count), 64'd3);
    chk("pc3", inst_pc, 64'd3);

    // 3: backpressure at pc 4
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", inst_pc, 64'd4);
      chk("hold_out", 64'(inst_out), 64'(mem[4]));
      chk("hold_addr", imem_addr, 64'd5);
      chk("hold_valid", 64'(inst_valid), 64'd1);
    end
    inst_ready = 1'b1;
    tick();
    chk("nobubble_pc", inst_pc, 64'd5);
    chk("nobubble_valid", 64'(inst_valid), 64'd1);
    chk("cnt5", 64'(fetch_count), 64'(exp_cnt));

    // 4: redirect over a valid&&ready slot, then out-of-range redirect
    tick(); tick();
    chk("pre_br_pc", inst_pc, 64'd7);
    br_taken = 1'b1; br_target = 64'd9;
    tick();
    br_taken = 1'b0;
    sb_q.delete();
    push_range(9, 63);
    chk("br_flush", 64'(inst_valid), 64'd0);
    chk("br_cnt", 64'(fetch_count), 64'd7);
    chk("br_addr", imem_addr, 64'd9);
    tick();
    chk("br_tgt_pc", inst_pc, 64'd9);
    chk("br_tgt_valid", 64'(inst_valid), 64'd1);
    tick();
    br_taken = 1'b1; br_target = 64'd64;
    tick();
    br_taken = 1'b0;
    sb_q.delete();
    chk("oob_fault", 64'(fault), 64'd1);
    chk("oob_done", 64'(done), 64'd1);
    chk("oob_valid", 64'(inst_valid), 64'd0);
    chk("oob_busy", 64'(busy), 64'd0);
    chk("oob_cnt", 64'(fetch_count), 64'(exp_cnt));
    br_taken = 1'b1; br_target = 64'd3;
    tick();
    br_taken = 1'b0;
    chk("done_ignores_br", imem_addr, 64'd11);

    // 5: full program to the end of memory
    start = 1'b1;
    push_range(0, 63);
    tick();
    start = 1'b0;
    chk("restart_fault_clr", 64'(fault), 64'd0);
    chk("restart_addr", imem_addr, 64'd0);
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("eop_done", 64'(done), 64'd1);
    chk("eop_cycles", 64'(cyc), 64'd65);
    chk("eop_drained", 64'(sb_q.size()), 64'd0);
    chk("eop_cnt", 64'(fetch_count), 64'd72);
    tick(); tick();
    chk("eop_addr", imem_addr, 64'd63);
    chk("eop_valid", 64'(inst_valid), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("eop_restart_addr", imem_addr, 64'd0);

    // halt with a coincident accept
    push_range(0, 0);
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_done", 64'(done), 64'd1);
    chk("halt_valid", 64'(inst_valid), 64'd0);
    chk("halt_cnt", 64'(fetch_count), 64'd73);

    // 6: reset in HOLD
    start = 1'b1; inst_ready = 1'b0;
    push_range(0, 0);
    tick();
    start = 1'b0;
    tick(); tick();
    chk("hold_busy", 64'(busy), 64'd1);
    inst_ready = 1'b1; reset_n = 1'b0;
    tick();
    sb_q.delete();
    exp_cnt = 0;
    reset_n = 1'b1; inst_ready = 1'b0;
    chk("rst6_valid", 64'(inst_valid), 64'd0);
    chk("rst6_cnt", 64'(fetch_count), 64'(exp_cnt));
    chk("rst6_busy", 64'(busy), 64'd0);
    chk("rst6_done", 64'(done), 64'd0);
    chk("rst6_addr", imem_addr, 64'd0);
    tick();
    chk("rst6_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
